// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM state encoding,
// default bus widths and the wait-counter width helper.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Bits needed to count 0..timeout_cycles; never narrower than one bit.
  function automatic int cnt_width(input int timeout_cycles);
    if (timeout_cycles > 0) begin
      return ($clog2(timeout_cycles + 1) > 0) ? $clog2(timeout_cycles + 1) : 1;
    end
    return 1;
  endfunction

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB requester: a command handshake starts one SETUP/ACCESS
// transfer and ends with a one-cycle registered response (with timeout).
module apb_master
  import apb_pkg::*;
#(
  parameter int data_width     = APB_DATA_W,
  parameter int addr_width     = APB_ADDR_W,
  parameter int timeout_cycles = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // Command side: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and the requester holds the command until taken.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [data_width-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB requester
  output logic [addr_width-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [data_width-1:0] pwdata,
  input  logic [data_width-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  // Debug visibility of the FSM
  output apb_state_e            dbg_state
);

  localparam int                CNT_W      = cnt_width(timeout_cycles);
  localparam bit                TIMEOUT_EN = (timeout_cycles > 0);
  localparam logic [CNT_W-1:0]  CNT_LAST   = TIMEOUT_EN ? CNT_W'(timeout_cycles - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  apb_state_e            state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [data_width-1:0] rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    cmd_ready   = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!write_q && !pslverr) ? prdata : '0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          // Saturate so a disabled timeout never wraps the count.
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data/direction come straight from the capture registers, so they
  // hold through IDLE and stay stable for the whole transfer.
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign pwrite    = write_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized bench for apb_master; expected responses come from
// a transfer-level model (latency, error and read-data rules) held in a queue.
module tb_apb_master;
  import apb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  apb_state_e    dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] exp_q[$];

  apb_master #(
    .data_width(DW), .addr_width(AW), .timeout_cycles(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer starting at a negedge in IDLE; returns at the response negedge.
  // waits < 0 means the completer never raises pready.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic err, input logic [DW-1:0] ret);
    bit to;
    bit done;
    int exp_acc, acc, k;
    logic exp_err;
    logic [DW-1:0] exp_rdata;
    to      = (waits < 0);
    exp_acc = to ? TO : waits + 1;
    exp_err = to || err;
    exp_q.push_back((wr || exp_err) ? '0 : ret);

    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; pready = 1'b0;
    @(negedge pclk);
    k = 1;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_paddr", paddr, addr);
    check("setup_pwdata", pwdata, wdata);
    check("setup_pwrite", pwrite, wr);
    check("setup_no_rsp", rsp_valid, 0);
    // Junk on the command bus while busy must be ignored.
    cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom_range(0, 1));
    cmd_addr = AW'($urandom); cmd_wdata = $urandom;

    acc = 0;
    done = 1'b0;
    for (int g = 0; g < TO + 10 && !done; g++) begin
      @(negedge pclk);
      k++;
      if (psel === 1'b1) begin
        acc++;
        check("acc_penable", penable, 1);
        check("acc_paddr", paddr, addr);
        check("acc_pwdata", pwdata, wdata);
        check("acc_pwrite", pwrite, wr);
        check("acc_no_rsp", rsp_valid, 0);
        pready  = !to && (acc == waits + 1);
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
        if (pready) begin
          prdata  = ret;
          pslverr = err;
        end
        cmd_valid = 1'($urandom_range(0, 1)); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
      end else begin
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0; pready = 1'b0; pslverr = 1'b0;
    check("rsp_seen", done, 1);
    check("access_cycles", acc, exp_acc);
    check("latency", k, exp_acc + 2);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_psel_low", psel, 0);
    check("rsp_penable_low", penable, 0);
    exp_rdata = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, exp_rdata);
  endtask

  initial begin
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #12;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("idle_no_rsp", rsp_valid, 0);

    // Zero-wait write then back-to-back read of the same location
    do_xfer(1'b1, 10'h003, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    do_xfer(1'b0, 10'h003, 32'h0, 0, 1'b0, 32'hDEADBEEF);
    // Three wait states
    do_xfer(1'b0, 10'h155, 32'h0, 3, 1'b0, 32'hA5A5_0F0F);
    // Completer never ready: timeout
    do_xfer(1'b1, 10'h3FF, 32'hCAFE_F00D, -1, 1'b0, 32'h0);
    // Slave error on a read
    do_xfer(1'b0, 10'h010, 32'h0, 0, 1'b1, 32'h12345678);
    // Just under the timeout limit still completes normally
    do_xfer(1'b0, 10'h020, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE);

    for (int i = 0; i < 24; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      do_xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom, w,
              ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge pclk);
        check("gap_no_rsp", rsp_valid, 0);
        check("gap_cmd_ready", cmd_ready, 1);
      end
    end

    // Reset in the middle of ACCESS aborts the transfer
    check("abort_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h2AA; cmd_wdata = 32'h1357_9BDF;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("abort_in_access", penable, 1);
    presetn = 1'b0;
    #1;
    check("abort_psel", psel, 0);
    check("abort_penable", penable, 0);
    check("abort_paddr", paddr, 0);
    check("abort_pwdata", pwdata, 0);
    check("abort_pwrite", pwrite, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    check("abort_hold_rsp", rsp_valid, 0);
    presetn = 1'b1;
    do_xfer(1'b0, 10'h0AB, 32'h0, 1, 1'b0, 32'h7777_1111);
    @(negedge pclk);
    check("final_no_rsp", rsp_valid, 0);
    check("final_cmd_ready", cmd_ready, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
